// File: rtl/operand_entry.sv
// Two-operand entry: synchronized switches latched by debounced k_1/k_2 presses.
// Optional macro OPERAND_ENTRY_KEY_CLEAR_EN: a press while both keys are held clears the entry.

module operand_entry_deb #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      if (din != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= din;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_q <= level;
      // Registered rising edge; this stage sets the N+3+DEB_CYCLES load latency.
      press   <= level & ~level_q;
    end
  end
endmodule

module operand_entry #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit0,
  input  logic       bit1,
  input  logic       bit2,
  input  logic       bit3,
  input  logic       k_1,
  input  logic       k_2,
  output logic [3:0] reg_1,
  output logic [3:0] reg_2,
  output logic       have_1,
  output logic       ready,
  output logic       load_done
);
  typedef enum logic [1:0] {EMPTY, HAVE1, FULL} state_t;

  state_t     state;
  logic [5:0] sync1, sync2;
  logic [3:0] sw;
  logic [1:0] lvl, prs;
  logic       clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {k_2, k_1, bit3, bit2, bit1, bit0};
      sync2 <= sync1;
    end
  end

  assign sw = sync2[3:0];

  for (genvar g = 0; g < 2; g++) begin : g_key
    operand_entry_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .din   (sync2[4+g]),
      .level (lvl[g]),
      .press (prs[g])
    );
  end

`ifdef OPERAND_ENTRY_KEY_CLEAR_EN
  assign clr = (|prs) & (&lvl);
`else
  logic unused_lvl;
  assign unused_lvl = ^lvl;
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      reg_1     <= '0;
      reg_2     <= '0;
      have_1    <= 1'b0;
      ready     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (clr) begin
        state  <= EMPTY;
        reg_1  <= '0;
        reg_2  <= '0;
        have_1 <= 1'b0;
        ready  <= 1'b0;
      end else if (prs[0]) begin
        // k_1 wins a tie; from FULL it restarts the entry.
        reg_1  <= sw;
        if (state == FULL) reg_2 <= '0;
        state  <= HAVE1;
        have_1 <= 1'b1;
        ready  <= 1'b0;
      end else if (prs[1] && state != EMPTY) begin
        reg_2     <= sw;
        load_done <= 1'b1;
        state     <= FULL;
        have_1    <= 1'b1;
        ready     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry at DEB_CYCLES=4; expectations follow the
// OPERAND_ENTRY_KEY_CLEAR_EN setting of the build.

module tb_operand_entry;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit0 = 0, bit1 = 0, bit2 = 0, bit3 = 0;
  logic       k_1 = 0, k_2 = 0;
  logic [3:0] reg_1, reg_2;
  logic       have_1, ready, load_done;

  int checks = 0;
  int errors = 0;
  int pulses;

  operand_entry #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bit0(bit0), .bit1(bit1), .bit2(bit2), .bit3(bit3),
    .k_1(k_1), .k_2(k_2), .reg_1(reg_1), .reg_2(reg_2),
    .have_1(have_1), .ready(ready), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    {bit3, bit2, bit1, bit0} = v;
  endtask

  // Advance n rising edges, returning 1ns after the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r1, input logic [3:0] r2,
                         input logic h, input logic rd);
    chk({tag, ".reg_1"}, reg_1, r1);
    chk({tag, ".reg_2"}, reg_2, r2);
    chk({tag, ".have_1"}, have_1, h);
    chk({tag, ".ready"}, ready, rd);
  endtask

  initial begin
    cyc(3);
    chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
    chk("reset.load_done", load_done, 1'b0);
    @(negedge clk) rst = 1'b0;
    cyc(3);

    // k_2 alone in EMPTY is ignored
    set_sw(4'b0111);
    @(negedge clk) k_2 = 1'b1;
    cyc(14);
    @(negedge clk) k_2 = 1'b0;
    cyc(12);
    chk_all("k2_empty", 4'd0, 4'd0, 1'b0, 1'b0);

    // exact latency: rise sampled at edge N, load at edge N+7
    set_sw(4'b0101);
    cyc(3);
    @(negedge clk) k_1 = 1'b1;
    cyc(7);
    chk("lat.before", reg_1, 4'd0);
    chk("lat.have_before", have_1, 1'b0);
    cyc(1);
    chk("lat.reg_1", reg_1, 4'd5);
    chk("lat.have_1", have_1, 1'b1);
    chk("lat.ready", ready, 1'b0);
    cyc(12);
    @(negedge clk) k_1 = 1'b0;
    cyc(12);
    chk_all("held_k1", 4'd5, 4'd0, 1'b1, 1'b0);

    // second operand with single load_done pulse
    set_sw(4'b1100);
    cyc(3);
    pulses = 0;
    @(negedge clk) k_2 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (load_done) pulses++;
    end
    @(negedge clk) k_2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (load_done) pulses++;
    end
    chk("k2.load_done_pulses", pulses, 1);
    chk_all("k2", 4'd5, 4'd12, 1'b1, 1'b1);

    // bounce shorter than DEB_CYCLES produces nothing
    set_sw(4'b1111);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk) k_1 = ~k_1;
      @(negedge clk);
    end
    k_1 = 1'b0;
    cyc(12);
    chk_all("bounce", 4'd5, 4'd12, 1'b1, 1'b1);

    // k_1 in FULL restarts the entry
    set_sw(4'b0011);
    cyc(3);
    @(negedge clk) k_1 = 1'b1;
    cyc(12);
    @(negedge clk) k_1 = 1'b0;
    cyc(12);
    chk_all("full_k1", 4'd3, 4'd0, 1'b1, 1'b0);

    // simultaneous rise from HAVE1
    set_sw(4'b1001);
    cyc(3);
    @(negedge clk) begin k_1 = 1'b1; k_2 = 1'b1; end
    cyc(12);
    @(negedge clk) begin k_1 = 1'b0; k_2 = 1'b0; end
    cyc(12);
`ifdef OPERAND_ENTRY_KEY_CLEAR_EN
    chk_all("both", 4'd0, 4'd0, 1'b0, 1'b0);
`else
    chk_all("both", 4'd9, 4'd0, 1'b1, 1'b0);
`endif

    // reset mid-debounce: pending count is discarded
    @(negedge clk) k_1 = 1'b1;
    cyc(4);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    cyc(2);
    @(negedge clk) k_1 = 1'b0;
    cyc(12);
    chk_all("rst_mid", 4'd0, 4'd0, 1'b0, 1'b0);
    chk("rst_mid.load_done", load_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have one parameter: DEB_CYCLES, default 50000, the number of consecutive stable cycles required to accept a key level change (legal range 1..2^20).
REQ-002 Port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Ports bit0, bit1, bit2, bit3, input, 1 each, the operand switch nibble; bit0 is the LSB.
REQ-005 Ports k_1 and k_2, input, 1 each, raw key inputs for operand 1 and operand 2, active-high and bouncing.
REQ-006 Port reg_1, output, 4, latched first operand, consumed by the arithmetic stage.
REQ-007 Port reg_2, output, 4, latched second operand, consumed by the arithmetic stage.
REQ-008 Port have_1, output, 1, level; high when reg_1 holds an entered value.
REQ-009 Port ready, output, 1, level; high when both operands are entered.
REQ-010 Port load_done, output, 1, one-cycle pulse on each reg_2 load.

Function
REQ-011 k_1, k_2 and bit0..bit3 SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each key SHALL have its own debouncer: a counter that increments while the synchronized input differs from the debounced level and clears otherwise. When the counter reaches DEB_CYCLES-1 while differing, the debounced level SHALL toggle and the counter SHALL clear.
REQ-013 A press event SHALL be a one-cycle pulse on the rising edge of a debounced level; release edges SHALL generate no event.
REQ-014 A raw key rise sampled at edge N SHALL update the target register at edge N+3+DEB_CYCLES, provided the raw input is held stable throughout.
REQ-015 The operand loaded SHALL be the synchronized switch nibble in the cycle the press event is high.
REQ-016 The state machine SHALL have three states: EMPTY, HAVE1 and FULL. have_1 SHALL be high in HAVE1 and FULL; ready SHALL be high in FULL only.
REQ-017 In EMPTY, a k_1 event SHALL load reg_1 and go to HAVE1. A k_2 event SHALL be ignored.
REQ-018 In HAVE1, a k_1 event SHALL reload reg_1 and stay in HAVE1. A k_2 event SHALL load reg_2, pulse load_done and go to FULL.
REQ-019 In FULL, a k_1 event SHALL load reg_1, clear reg_2 to 0 and go to HAVE1, starting a new entry. A k_2 event SHALL reload reg_2, pulse load_done and stay in FULL.
REQ-020 If k_1 and k_2 events occur in the same cycle, k_1 SHALL take priority and the k_2 event SHALL be discarded (subject to REQ-025).
REQ-021 Holding a key SHALL produce exactly one event; bounces shorter than DEB_CYCLES SHALL produce none.

Reset
REQ-022 While rst is high: state = EMPTY; reg_1 = 0; reg_2 = 0; have_1 = 0; ready = 0; load_done = 0; debounced levels = 0; all counters = 0; synchronizers = 0.
REQ-023 An rst assertion mid-debounce SHALL discard the pending count; after release, a key already held high SHALL need a full DEB_CYCLES to register.
REQ-024 No press event SHALL be generated in the first cycle after rst deasserts.

Configuration
REQ-025 With macro OPERAND_ENTRY_KEY_CLEAR_EN defined: when any press event occurs while both debounced levels are high, the block SHALL go to EMPTY, clear reg_1 and reg_2, and load nothing. This rule overrides REQ-017 through REQ-020. Without the macro, REQ-020 applies unchanged and no clear path exists.

Verification (DEB_CYCLES=4)
REQ-026 Reset, switches=0101, k_1 held high 20 cycles: reg_1=5 and have_1=1 exactly 7 edges after the rise; ready=0.
REQ-027 Then switches=1100, k_2 held high: reg_2=12, ready=1, and load_done high for exactly one cycle.
REQ-028 k_1 toggled every 2 cycles for 30 cycles, then held low: no load occurs, and reg_1 and state are unchanged.
REQ-029 In FULL, switches=0011, k_1 pressed: reg_1=3, reg_2=0, state HAVE1, ready=0; a k_2 press in EMPTY after reset leaves all outputs at 0.
REQ-030 k_1 and k_2 rise in the same cycle from HAVE1. Macro undefined: reg_1 reloads, state stays HAVE1. Macro defined: all outputs return to 0. rst pulsed mid-debounce: no load follows.
